// File: rtl/send_arbiter.sv
// Round-robin arbiter sharing one serial sender between two pattern sources.
// Queues one request per source, latches the winner's word, pulses sendGo and tracks sendBusy.
module send_arbiter #(
  parameter int WIDTH       = 120,
  parameter int ACK_TIMEOUT = 16,
  parameter int GAP         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go0,
  input  logic [WIDTH-1:0] data0,
  input  logic             go1,
  input  logic [WIDTH-1:0] data1,
  output logic             ready0,
  output logic             ready1,
  output logic             sendGo,
  output logic [WIDTH-1:0] sendData,
  input  logic             sendBusy,
  output logic [1:0]       grant,
  output logic             timeoutErr
);

  // state     | meaning
  // IDLE      | no transfer; pick a winner from the pending requests
  // START     | one-cycle sendGo to the sender
  // WAIT_ACK  | waiting for sendBusy to rise, bounded by ACK_TIMEOUT
  // WAIT_DONE | sender shifting; wait for sendBusy to fall
  // GAP       | enforced idle time before the next grant
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_ACK  = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  localparam int CNT_MAX = (ACK_TIMEOUT > GAP) ? ACK_TIMEOUT : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] ACK_TC = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_TC = CW'(GAP - 1);

  logic [2:0]       state_q, state_d;
  logic             pend0_q, pend0_d;
  logic             pend1_q, pend1_d;
  logic             go0_prev_q, go0_prev_d;
  logic             go1_prev_q, go1_prev_d;
  logic             last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       grant_q, grant_d;
  logic             tmo_q, tmo_d;

  logic rise0, rise1;
  logic clr0, clr1;
  logic win;

  assign rise0      = go0 & ~go0_prev_q;
  assign rise1      = go1 & ~go1_prev_q;
  assign go0_prev_d = go0;
  assign go1_prev_d = go1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    grant_d = grant_q;
    last_d  = last_q;
    tmo_d   = 1'b0;
    clr0    = 1'b0;
    clr1    = 1'b0;
    win     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend0_q || pend1_q) begin
          // on a tie the requester that did not win last time goes first
          win     = (pend0_q && pend1_q) ? ~last_q : pend1_q;
          data_d  = win ? data1 : data0;
          grant_d = win ? 2'b10 : 2'b01;
          last_d  = win;
          clr0    = ~win;
          clr1    = win;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (sendBusy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == ACK_TC) begin
          tmo_d   = 1'b1;
          grant_d = 2'b00;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!sendBusy) begin
          grant_d = 2'b00;
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_TC) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
    endcase
    // a new edge in the granting cycle keeps the request queued
    pend0_d = rise0 | (pend0_q & ~clr0);
    pend1_d = rise1 | (pend1_q & ~clr1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pend0_q    <= 1'b0;
      pend1_q    <= 1'b0;
      go0_prev_q <= 1'b0;
      go1_prev_q <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      data_q     <= '0;
      grant_q    <= 2'b00;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend0_q    <= pend0_d;
      pend1_q    <= pend1_d;
      go0_prev_q <= go0_prev_d;
      go1_prev_q <= go1_prev_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      grant_q    <= grant_d;
      tmo_q      <= tmo_d;
    end
  end

  assign sendGo     = (state_q == S_START);
  assign sendData   = data_q;
  assign grant      = grant_q;
  assign timeoutErr = tmo_q;
  assign ready0     = ~pend0_q & (grant_q != 2'b01);
  assign ready1     = ~pend1_q & (grant_q != 2'b10);

endmodule

// File: tb/tb_send_arbiter.sv
// Directed bench for send_arbiter: request capture, round-robin order, gap timing,
// ack timeout and asynchronous reset, with hand-computed expectations.
module tb_send_arbiter;
  localparam int WIDTH = 120;
  localparam logic [WIDTH-1:0] D_A5 = {15{8'hA5}};
  localparam logic [WIDTH-1:0] D_3C = {15{8'h3C}};
  localparam logic [WIDTH-1:0] D_0 = {15{8'h11}};
  localparam logic [WIDTH-1:0] D_1 = {15{8'h22}};
  localparam logic [WIDTH-1:0] D_2 = {15{8'h33}};
  localparam logic [WIDTH-1:0] D_3 = {15{8'h44}};
  localparam logic [WIDTH-1:0] D_4 = {15{8'h55}};
  localparam logic [WIDTH-1:0] D_5 = {15{8'h66}};
  localparam logic [WIDTH-1:0] D_6 = {15{8'h77}};
  localparam logic [WIDTH-1:0] D_7 = {15{8'h88}};
  localparam logic [WIDTH-1:0] D_8 = {15{8'h99}};

  logic             clk = 1'b0;
  logic             reset;
  logic             go0, go1;
  logic [WIDTH-1:0] data0, data1;
  logic             ready0, ready1;
  logic             sendGo;
  logic [WIDTH-1:0] sendData;
  logic             sendBusy;
  logic [1:0]       grant;
  logic             timeoutErr;

  int checks = 0;
  int failures = 0;
  int go_cnt = 0;
  int tmo_cnt = 0;
  int g;
  int t;

  always #5 clk = ~clk;

  send_arbiter #(.WIDTH(WIDTH), .ACK_TIMEOUT(16), .GAP(4)) dut (
    .clk(clk), .reset(reset),
    .go0(go0), .data0(data0), .go1(go1), .data1(data1),
    .ready0(ready0), .ready1(ready1),
    .sendGo(sendGo), .sendData(sendData), .sendBusy(sendBusy),
    .grant(grant), .timeoutErr(timeoutErr)
  );

  always @(negedge clk) begin
    if (sendGo === 1'b1) go_cnt++;
    if (timeoutErr === 1'b1) tmo_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge inside a START cycle; returns at the negedge right after IDLE is re-entered.
  task automatic finish_xfer();
    @(negedge clk);
    sendBusy = 1'b1;
    repeat (2) @(negedge clk);
    sendBusy = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; go0 = 1'b0; go1 = 1'b0; data0 = '0; data1 = '0; sendBusy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_sendgo", sendGo, 0);
    chk("rst_ready0", ready0, 1);
    chk("rst_ready1", ready1, 1);
    chk("rst_senddata", sendData, 0);
    chk("rst_timeout", timeoutErr, 0);
    reset = 1'b1;
    @(negedge clk);

    // single request
    g = go_cnt;
    data0 = D_A5; go0 = 1'b1;
    @(negedge clk);
    chk("t1_ready0_pend", ready0, 0);
    chk("t1_grant_before", grant, 0);
    chk("t1_sendgo_before", sendGo, 0);
    go0 = 1'b0;
    @(negedge clk);
    chk("t1_sendgo_start", sendGo, 1);
    chk("t1_grant", grant, 2'b01);
    chk("t1_senddata", sendData, D_A5);
    chk("t1_ready0_busy", ready0, 0);
    @(negedge clk);
    chk("t1_sendgo_after", sendGo, 0);
    @(negedge clk);
    sendBusy = 1'b1;
    repeat (10) @(negedge clk);
    chk("t1_grant_held", grant, 2'b01);
    chk("t1_ready0_held", ready0, 0);
    sendBusy = 1'b0;
    @(negedge clk);
    chk("t1_grant_clear", grant, 0);
    chk("t1_ready0_free", ready0, 1);
    chk("t1_one_pulse", go_cnt - g, 1);
    data0 = D_3C; go0 = 1'b1;
    @(negedge clk);
    go0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_gap_nogrant", grant, 0);
    chk("t1_gap_nosendgo", sendGo, 0);
    @(negedge clk);
    chk("t1_idle_grant", grant, 2'b01);
    chk("t1_idle_sendgo", sendGo, 1);
    chk("t1_idle_data", sendData, D_3C);
    finish_xfer();

    // simultaneous requests right after reset
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    data0 = D_0; data1 = D_1; go0 = 1'b1; go1 = 1'b1;
    @(negedge clk);
    go0 = 1'b0; go1 = 1'b0;
    chk("t2_ready0", ready0, 0);
    chk("t2_ready1", ready1, 0);
    @(negedge clk);
    chk("t2_first_grant", grant, 2'b01);
    chk("t2_first_data", sendData, D_0);
    finish_xfer();
    @(negedge clk);
    chk("t2_second_grant", grant, 2'b10);
    chk("t2_second_data", sendData, D_1);
    chk("t2_second_sendgo", sendGo, 1);
    finish_xfer();
    go0 = 1'b1; go1 = 1'b1;
    @(negedge clk);
    go0 = 1'b0; go1 = 1'b0;
    @(negedge clk);
    chk("t2_pair2_first", grant, 2'b01);
    finish_xfer();
    @(negedge clk);
    chk("t2_pair2_second", grant, 2'b10);
    finish_xfer();
    @(negedge clk);
    chk("t2_drained_grant", grant, 0);
    chk("t2_drained_sendgo", sendGo, 0);

    // back-to-back: go1 during requester 0's WAIT_DONE
    data0 = D_2; go0 = 1'b1;
    @(negedge clk);
    go0 = 1'b0;
    @(negedge clk);
    chk("t3_grant0", grant, 2'b01);
    @(negedge clk);
    sendBusy = 1'b1;
    @(negedge clk);
    data1 = D_3; go1 = 1'b1;
    @(negedge clk);
    go1 = 1'b0;
    chk("t3_ready1_low", ready1, 0);
    chk("t3_grant_still0", grant, 2'b01);
    chk("t3_data_still0", sendData, D_2);
    sendBusy = 1'b0;
    repeat (5) @(negedge clk);
    chk("t3_gap_grant", grant, 0);
    chk("t3_gap_data", sendData, D_2);
    chk("t3_gap_ready1", ready1, 0);
    @(negedge clk);
    chk("t3_grant1", grant, 2'b10);
    chk("t3_data1", sendData, D_3);
    chk("t3_sendgo1", sendGo, 1);
    finish_xfer();

    // ack timeout with a queued request on port 1
    data0 = D_4; data1 = D_5; go0 = 1'b1;
    @(negedge clk);
    go0 = 1'b0;
    @(negedge clk);
    chk("t4_start_sendgo", sendGo, 1);
    chk("t4_start_grant", grant, 2'b01);
    t = tmo_cnt;
    @(negedge clk);
    go1 = 1'b1;
    @(negedge clk);
    go1 = 1'b0;
    repeat (14) @(negedge clk);
    chk("t4_no_early_tmo", tmo_cnt - t, 0);
    chk("t4_grant_waiting", grant, 2'b01);
    @(negedge clk);
    chk("t4_tmo_pulse", timeoutErr, 1);
    chk("t4_tmo_grant", grant, 0);
    chk("t4_tmo_ready1", ready1, 0);
    @(negedge clk);
    chk("t4_tmo_oneshot", timeoutErr, 0);
    chk("t4_tmo_count", tmo_cnt - t, 1);
    repeat (3) @(negedge clk);
    chk("t4_gap_grant", grant, 0);
    @(negedge clk);
    chk("t4_next_grant", grant, 2'b10);
    chk("t4_next_data", sendData, D_5);
    chk("t4_next_sendgo", sendGo, 1);
    finish_xfer();

    // reset in WAIT_DONE with pend1 set
    data0 = D_6; go0 = 1'b1;
    @(negedge clk);
    go0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sendBusy = 1'b1;
    @(negedge clk);
    data1 = D_7; go1 = 1'b1;
    @(negedge clk);
    go1 = 1'b0;
    chk("t5_pend1", ready1, 0);
    #2;
    reset = 1'b0;
    sendBusy = 1'b0;
    #1;
    chk("t5_async_grant", grant, 0);
    chk("t5_async_sendgo", sendGo, 0);
    chk("t5_async_ready0", ready0, 1);
    chk("t5_async_ready1", ready1, 1);
    chk("t5_async_data", sendData, 0);
    @(negedge clk);
    reset = 1'b1;
    g = go_cnt;
    repeat (8) @(negedge clk);
    chk("t5_no_sendgo", go_cnt - g, 0);
    chk("t5_idle_grant", grant, 0);

    // repeated go0 edges while pend0 already set
    data1 = D_7; go1 = 1'b1;
    @(negedge clk);
    go1 = 1'b0;
    @(negedge clk);
    chk("t6_grant1", grant, 2'b10);
    @(negedge clk);
    g = go_cnt;
    sendBusy = 1'b1; data0 = D_8; go0 = 1'b1;
    @(negedge clk);
    go0 = 1'b0;
    @(negedge clk);
    go0 = 1'b1;
    @(negedge clk);
    go0 = 1'b0;
    chk("t6_ready0_low", ready0, 0);
    sendBusy = 1'b0;
    repeat (5) @(negedge clk);
    @(negedge clk);
    chk("t6_grant0", grant, 2'b01);
    chk("t6_data0", sendData, D_8);
    finish_xfer();
    repeat (10) @(negedge clk);
    chk("t6_single_xfer", go_cnt - g, 1);
    chk("t6_final_grant", grant, 0);
    chk("t6_final_ready0", ready0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
